acorn128_decrypt_core: RTL and testbench

//  Bit-serial ACORN-128 decryption engine: the receive-side counterpart of the encrypt-side state update.

---
 rtl/acorn128_pkg.sv | 38 +++
 rtl/acorn128_step.sv | 38 +++
 rtl/acorn128_decrypt_core.sv | 130 +++++++++++++
 tb/tb_acorn128_decrypt_core.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acorn128_pkg.sv
// Shared ACORN-128 definitions: state geometry, feedback tap positions, boolean helpers
// and the decrypt-core FSM encoding. Used by the encrypt/decrypt update paths and init.
package acorn128_pkg;

  localparam int STATE_W = 293;

  localparam int T0   = 0;
  localparam int T12  = 12;
  localparam int T23  = 23;
  localparam int T61  = 61;
  localparam int T66  = 66;
  localparam int T107 = 107;
  localparam int T111 = 111;
  localparam int T154 = 154;
  localparam int T160 = 160;
  localparam int T193 = 193;
  localparam int T196 = 196;
  localparam int T230 = 230;
  localparam int T235 = 235;
  localparam int T244 = 244;
  localparam int T289 = 289;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_CT,
    ST_RUN,
    ST_PAD
  } acorn_fsm_e;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

endpackage

// File: rtl/acorn128_step.sv
// Combinational single ACORN-128 state step. dec_mode=1 feeds back p = c ^ ks,
// dec_mode=0 feeds back m_or_c directly (encrypt / padding use).
module acorn128_step
  import acorn128_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic               ca,
  input  logic               cb,
  input  logic               dec_mode,
  input  logic               m_or_c,
  output logic [STATE_W-1:0] state_nxt,
  output logic               ks,
  output logic               p
);

  logic [STATE_W-1:0] s;
  logic               f;
  logic               m;

  always_comb begin
    // LFSR feedback; every term reads the pre-step state
    s       = state;
    s[T289] = state[T289] ^ state[T235] ^ state[T230];
    s[T230] = state[T230] ^ state[T196] ^ state[T193];
    s[T193] = state[T193] ^ state[T160] ^ state[T154];
    s[T154] = state[T154] ^ state[T111] ^ state[T107];
    s[T107] = state[T107] ^ state[T66]  ^ state[T61];
    s[T61]  = state[T61]  ^ state[T23]  ^ state[T0];

    ks = s[T12] ^ s[T154] ^ maj(s[T235], s[T61], s[T193]) ^ ch(s[T230], s[T111], s[T66]);
    f  = s[T0] ^ ~s[T107] ^ maj(s[T244], s[T23], s[T160]) ^ (ca & s[T196]) ^ (cb & ks);
    p  = m_or_c ^ ks;
    m  = dec_mode ? p : m_or_c;

    state_nxt = {f ^ m, s[STATE_W-1:1]};
  end

endmodule

// File: rtl/acorn128_decrypt_core.sv
// Bit-serial ACORN-128 decryption: one state step per cycle over each ciphertext beat,
// then the padding phase; final state is left on state_out for tag generation.
module acorn128_decrypt_core
  import acorn128_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PAD_STEPS = 256,
  parameter int CA_STEPS  = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               empty_msg,
  input  logic [STATE_W-1:0] state_in,
  input  logic               ct_valid,
  output logic               ct_ready,
  input  logic [DATA_W-1:0]  ct_data,
  input  logic               ct_last,
  output logic               pt_valid,
  input  logic               pt_ready,
  output logic [DATA_W-1:0]  pt_data,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] state_out
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int SW = (PAD_STEPS > 1) ? $clog2(PAD_STEPS) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(PAD_STEPS - 1);

  acorn_fsm_e         fsm, fsm_nxt;
  logic [STATE_W-1:0] st_q, st_step;
  logic [BW-1:0]      bit_cnt;
  logic [SW-1:0]      step_cnt;
  logic [DATA_W-1:0]  ct_sr, pt_asm, pt_buf;
  logic               last_q, pt_vld_q, done_q;
  logic               run, ca, m_or_c, p, ks_unused;
  logic               ct_hs, pt_hs;

  assign run      = (fsm == ST_RUN);
  assign pt_hs    = pt_vld_q & pt_ready;
  assign ct_ready = (fsm == ST_WAIT_CT) && (!pt_vld_q || pt_ready);
  assign ct_hs    = ct_valid & ct_ready;

  // Padding: first step injects a 1, ca stays high for the leading CA_STEPS steps
  assign ca     = run | ({1'b0, step_cnt} < (SW+1)'(CA_STEPS));
  assign m_or_c = run ? ct_sr[0] : (step_cnt == '0);

  acorn128_step u_step (
    .state     (st_q),
    .ca        (ca),
    .cb        (1'b0),
    .dec_mode  (run),
    .m_or_c    (m_or_c),
    .state_nxt (st_step),
    .ks        (ks_unused),
    .p         (p)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fsm <= ST_IDLE;
    else      fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      ST_IDLE:    if (start) fsm_nxt = empty_msg ? ST_PAD : ST_WAIT_CT;
      ST_WAIT_CT: if (ct_hs) fsm_nxt = ST_RUN;
      ST_RUN:     if (bit_cnt == BIT_LAST) fsm_nxt = last_q ? ST_PAD : ST_WAIT_CT;
      ST_PAD:     if (step_cnt == STEP_LAST) fsm_nxt = ST_IDLE;
      default:    fsm_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= '0;
      bit_cnt  <= '0;
      step_cnt <= '0;
      ct_sr    <= '0;
      pt_asm   <= '0;
      pt_buf   <= '0;
      last_q   <= 1'b0;
      pt_vld_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pt_hs) pt_vld_q <= 1'b0;
      case (fsm)
        ST_IDLE: if (start) begin
          st_q     <= state_in;
          bit_cnt  <= '0;
          step_cnt <= '0;
        end
        ST_WAIT_CT: if (ct_hs) begin
          ct_sr   <= ct_data;
          last_q  <= ct_last;
          bit_cnt <= '0;
        end
        ST_RUN: begin
          st_q    <= st_step;
          ct_sr   <= ct_sr >> 1;
          pt_asm  <= {p, pt_asm[DATA_W-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          // Buffer is guaranteed empty here: a beat is only accepted once it has drained
          if (bit_cnt == BIT_LAST) begin
            pt_buf   <= {p, pt_asm[DATA_W-1:1]};
            pt_vld_q <= 1'b1;
            step_cnt <= '0;
          end
        end
        ST_PAD: begin
          st_q <= st_step;
          if (step_cnt == STEP_LAST) done_q   <= 1'b1;
          else                       step_cnt <= step_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pt_valid  = pt_vld_q;
  assign pt_data   = pt_buf;
  assign busy      = (fsm != ST_IDLE);
  assign done      = done_q;
  assign state_out = st_q;

endmodule

// File: tb/tb_acorn128_decrypt_core.sv
// Scoreboard bench: messages are encrypted by an algorithm-level ACORN model, the ciphertext
// is driven into the core, and a monitor checks each plaintext beat and the final state.
module tb_acorn128_decrypt_core;

  localparam int DW = 8;
  localparam int SWID = 293;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            empty_msg = 1'b0;
  logic [SWID-1:0] state_in = '0;
  logic            ct_valid = 1'b0;
  logic            ct_ready;
  logic [DW-1:0]   ct_data = '0;
  logic            ct_last = 1'b0;
  logic            pt_valid;
  logic            pt_ready = 1'b0;
  logic [DW-1:0]   pt_data;
  logic            busy;
  logic            done;
  logic [SWID-1:0] state_out;

  acorn128_decrypt_core #(.DATA_W(DW), .PAD_STEPS(256), .CA_STEPS(128)) dut (
    .clk(clk), .rst(rst), .start(start), .empty_msg(empty_msg), .state_in(state_in),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data), .ct_last(ct_last),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .busy(busy), .done(done), .state_out(state_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0]   exp_pt[$];
  logic [SWID-1:0] exp_st[$];
  logic [DW-1:0]   ct_m[16];
  bit hold = 1'b0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [SWID-1:0] act, input logic [SWID-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: ACORN-128 written from the algorithm ----------------
  function automatic bit maj3(input bit x, input bit y, input bit z);
    return (x & y) | (x & z) | (y & z);
  endfunction
  function automatic bit ch3(input bit x, input bit y, input bit z);
    return x ? y : z;
  endfunction
  // Six LFSR feedbacks applied one after another (each reads only not-yet-updated taps)
  function automatic bit [SWID-1:0] upd(input bit [SWID-1:0] si);
    bit [SWID-1:0] s;
    s = si;
    s[289] = s[289] ^ s[235] ^ s[230];
    s[230] = s[230] ^ s[196] ^ s[193];
    s[193] = s[193] ^ s[160] ^ s[154];
    s[154] = s[154] ^ s[111] ^ s[107];
    s[107] = s[107] ^ s[66]  ^ s[61];
    s[61]  = s[61]  ^ s[23]  ^ s[0];
    return s;
  endfunction
  function automatic bit ks_of(input bit [SWID-1:0] u);
    return u[12] ^ u[154] ^ maj3(u[235], u[61], u[193]) ^ ch3(u[230], u[111], u[66]);
  endfunction
  function automatic bit [SWID-1:0] adv(input bit [SWID-1:0] u, input bit ca, input bit cb,
                                         input bit m, input bit ks);
    bit f;
    f = u[0] ^ !u[107] ^ maj3(u[244], u[23], u[160]) ^ (ca & u[196]) ^ (cb & ks);
    return (u >> 1) | ({{(SWID-1){1'b0}}, f ^ m} << (SWID-1));
  endfunction
  function automatic bit [SWID-1:0] pad_model(input bit [SWID-1:0] si);
    bit [SWID-1:0] s, u;
    s = si;
    for (int j = 0; j < 256; j++) begin
      u = upd(s);
      s = adv(u, j < 128, 1'b0, j == 0, ks_of(u));
    end
    return s;
  endfunction
  // Key/IV load with key=0, IV=0: the only nonzero input bit is the key[0]^1 at step 256
  function automatic bit [SWID-1:0] init_zero_model();
    bit [SWID-1:0] s, u;
    s = '0;
    for (int i = 0; i < 1792; i++) begin
      u = upd(s);
      s = adv(u, 1'b1, 1'b1, i == 256, ks_of(u));
    end
    return s;
  endfunction

  // Encrypt a message with the model, queue plaintext and final state as expectations
  task automatic build_msg(input bit [SWID-1:0] s_init, input int n, input bit zero_pt);
    bit [SWID-1:0] s, u;
    bit [DW-1:0]   pb, cb8;
    bit            ks;
    s = s_init;
    for (int i = 0; i < n; i++) begin
      pb = zero_pt ? '0 : DW'($urandom);
      for (int b = 0; b < DW; b++) begin
        u = upd(s);
        ks = ks_of(u);
        cb8[b] = pb[b] ^ ks;
        s = adv(u, 1'b1, 1'b0, pb[b], ks);
      end
      ct_m[i] = cb8;
      exp_pt.push_back(pb);
    end
    exp_st.push_back(pad_model(s));
  endtask

  function automatic bit [SWID-1:0] rand_state();
    bit [SWID-1:0] s;
    for (int i = 0; i < SWID; i += 32) s = (s << 32) | SWID'($urandom);
    return s;
  endfunction

  // ---------------- drivers ----------------
  always begin
    @(posedge clk); #1;
    if (hold)            pt_ready = 1'b0;
    else if (rand_ready) pt_ready = ($urandom_range(0, 3) != 0);
    else                 pt_ready = 1'b1;
  end

  task automatic wait_for(input int sel, input string name, output int at);
    bit hit;
    hit = 1'b0;
    at = 0;
    for (int k = 0; k < 3000 && !hit; k++) begin
      @(negedge clk);
      hit = (sel == 0) ? pt_valid : (sel == 1) ? done : !busy;
    end
    if (hit) at = cyc;
    else begin
      checks++; errors++;
      $display("FAIL timeout_%s: got no event expected event within 3000 cycles", name);
    end
  endtask

  task automatic start_msg(input bit [SWID-1:0] s, input bit empty, output int at);
    int t;
    wait_for(2, "idle", t);
    @(posedge clk); #1;
    start = 1'b1; empty_msg = empty; state_in = s;
    @(posedge clk); #1;
    start = 1'b0; empty_msg = 1'b0;
    at = cyc;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit last, output int at);
    bit ok;
    ok = 1'b0;
    ct_valid = 1'b1; ct_data = d; ct_last = last;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      if (ct_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    ct_valid = 1'b0; ct_last = 1'b0;
    at = cyc;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL timeout_ct: got ct_ready=0 expected a handshake");
    end
  endtask

  task automatic send_msg(input int n);
    int t;
    for (int i = 0; i < n; i++) send_beat(ct_m[i], i == n - 1, t);
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit            held = 1'b0;
  logic [DW-1:0] held_data = '0;
  always @(negedge clk) begin
    if (!rst) begin
      held = 1'b0;
    end else begin
      if (held && pt_valid) check("pt_stable", pt_data, held_data);
      if (pt_valid && !pt_ready) check("ct_ready_blocked", ct_ready, 0);
      if (pt_valid && pt_ready) begin
        if (exp_pt.size() == 0) check("unexpected_pt", 1, 0);
        else check("pt_data", pt_data, exp_pt.pop_front());
      end
      if (done) begin
        check("busy_at_done", busy, 0);
        if (exp_st.size() == 0) check("unexpected_done", 1, 0);
        else check("state_out", state_out, exp_st.pop_front());
      end
      held = pt_valid && !pt_ready;
      held_data = pt_data;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before 90000 cycles");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int ta, tb, tc;
    bit [SWID-1:0] s0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ct_ready", ct_ready, 0);
    check("rst_pt_valid", pt_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pt_data", pt_data, 0);
    check("rst_state_out", state_out, 0);
    rst = 1'b1;

    // 1: zero state, zero ciphertext -> zero plaintext; latency of pt_valid and done
    build_msg('0, 1, 1'b1);
    start_msg('0, 1'b0, ta);
    send_beat(ct_m[0], 1'b1, ta);
    wait_for(0, "pt_valid", tb);
    check("pt_latency", tb - ta, DW);
    wait_for(1, "done", tc);
    check("done_latency", tc - tb, 256);

    // 4: empty message goes straight to padding
    s0 = rand_state();
    build_msg(s0, 0, 1'b0);
    start_msg(s0, 1'b1, ta);
    wait_for(1, "done_empty", tb);
    check("empty_done_latency", tb - ta, 256);

    // 2: key=0/IV=0 initial state, 16-byte message
    rand_ready = 1'b1;
    s0 = init_zero_model();
    build_msg(s0, 16, 1'b0);
    start_msg(s0, 1'b0, ta);
    send_msg(16);

    // 3: downstream stall for 20 cycles after the first beat
    rand_ready = 1'b0;
    hold = 1'b1;
    s0 = rand_state();
    build_msg(s0, 3, 1'b0);
    start_msg(s0, 1'b0, ta);
    fork
      send_msg(3);
      begin
        wait_for(0, "pt_hold", tb);
        repeat (20) begin
          @(negedge clk);
          check("hold_ct_ready", ct_ready, 0);
          check("hold_pt_valid", pt_valid, 1);
        end
        hold = 1'b0;
        @(negedge clk);
        check("release_ct_ready", ct_ready, 1);
        check("release_pt_ready", pt_ready, 1);
      end
    join

    // 6: start pulsed during padding must be ignored
    rand_ready = 1'b1;
    s0 = rand_state();
    build_msg(s0, 2, 1'b0);
    start_msg(s0, 1'b0, ta);
    send_msg(2);
    repeat (20) @(posedge clk);
    #1;
    start = 1'b1; state_in = rand_state();
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_ignored_start", busy, 1);

    // 5: reset at bit 4 of beat 3, then a fresh message
    s0 = rand_state();
    build_msg(s0, 5, 1'b0);
    start_msg(s0, 1'b0, ta);
    send_beat(ct_m[0], 1'b0, ta);
    send_beat(ct_m[1], 1'b0, ta);
    send_beat(ct_m[2], 1'b0, ta);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_ct_ready", ct_ready, 0);
    check("abort_pt_valid", pt_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_pt_data", pt_data, 0);
    check("abort_state_out", state_out, 0);
    exp_pt.delete();
    exp_st.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // randomized messages
    for (int r = 0; r < 5; r++) begin
      int n;
      n = $urandom_range(1, 6);
      s0 = rand_state();
      build_msg(s0, n, 1'b0);
      start_msg(s0, 1'b0, ta);
      send_msg(n);
    end

    wait_for(2, "final_idle", tb);
    rand_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_pt.size() + exp_st.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
